rom_fetch_responder: RTL



---
 rtl/dg0045_pkg.sv | 23 ++
 rtl/rom_fetch_mem.sv | 32 +++
 rtl/rom_fetch_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dg0045_pkg.sv
// Shared types and widths for the DG0045 fetch-bus responder.
// ROM_BANK_EN widens the fetch address by a 2-bit page select.
package dg0045_pkg;

    localparam int unsigned PC_W   = 10;
    localparam int unsigned HALF_W = 5;
    localparam logic [7:0]  NOP    = 8'h00;

`ifdef ROM_BANK_EN
    localparam int unsigned ADDR_W = PC_W + 2;
`else
    localparam int unsigned ADDR_W = PC_W;
`endif

    typedef enum logic [2:0] {
        SEL_LO,
        SEL_HI,
        CMP,
        LOOKUP,
        DRIVE
    } fetch_state_e;

endpackage

// File: rtl/rom_fetch_mem.sv
// Loadable instruction store: one write port, one registered read port,
// write-first when both ports hit the same word in the same clock.
module rom_fetch_mem #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = we && (32'(waddr) < DEPTH);

    // Array is deliberately not reset so a core reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (wr_ok && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/rom_fetch_responder.sv
// Target end of the DG0045 multiplexed fetch bus: captures the PC in two halves,
// commits it after two identical captures and drives the ROM byte. Option: ROM_BANK_EN.
module rom_fetch_responder
    import dg0045_pkg::*;
#(
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned ROM_DEPTH = 1024,
    parameter logic [7:0]  NOP_BYTE  = NOP
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [HALF_W-1:0] pc_hl,
`ifdef ROM_BANK_EN
    input  logic [1:0]        ps,
`endif
    output logic              pc_mux,
    output logic [7:0]        rom_data,
    output logic              data_valid,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

`ifdef ROM_BANK_EN
    localparam int unsigned MEM_DEPTH = 4 * ROM_DEPTH;
`else
    localparam int unsigned MEM_DEPTH = ROM_DEPTH;
`endif

    fetch_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [HALF_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [1:0]        ps_q, ps_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d, cap_addr;
    logic              prev_ok_q, prev_ok_d;
    logic [7:0]        rom_data_d;
    logic              data_valid_d;
    logic [ADDR_W-1:0] fetch_addr_d;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              settle_done;

`ifdef ROM_BANK_EN
    assign cap_addr = {ps_q, hi_q, lo_q};
`else
    assign cap_addr = {hi_q, lo_q};
`endif

    assign settle_done = (cnt_q == 4'(SETTLE - 1));
    assign pc_mux      = (state_q == SEL_HI);

    rom_fetch_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_mem (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (rd_en),
        .raddr (prev_addr_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= SEL_LO;
            cnt_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            ps_q        <= '0;
            prev_addr_q <= '0;
            prev_ok_q   <= 1'b0;
            rom_data    <= NOP_BYTE;
            data_valid  <= 1'b0;
            fetch_addr  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            ps_q        <= ps_d;
            prev_addr_q <= prev_addr_d;
            prev_ok_q   <= prev_ok_d;
            rom_data    <= rom_data_d;
            data_valid  <= data_valid_d;
            fetch_addr  <= fetch_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        lo_d         = lo_q;
        hi_d         = hi_q;
        ps_d         = ps_q;
        prev_addr_d  = prev_addr_q;
        prev_ok_d    = prev_ok_q;
        rom_data_d   = rom_data;
        data_valid_d = data_valid;
        fetch_addr_d = fetch_addr;
        rd_en        = 1'b0;

        unique case (state_q)
            SEL_LO: begin
                if (settle_done) begin
                    lo_d    = pc_hl;
                    state_d = SEL_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SEL_HI: begin
                if (settle_done) begin
                    hi_d    = pc_hl;
`ifdef ROM_BANK_EN
                    ps_d    = ps;
`endif
                    state_d = CMP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CMP: begin
                // A capture only commits when it matches the previous round's capture.
                if (prev_ok_q && (cap_addr == prev_addr_q)) begin
                    state_d = LOOKUP;
                end else begin
                    prev_addr_d = cap_addr;
                    prev_ok_d   = 1'b1;
                    state_d     = SEL_LO;
                end
            end
            LOOKUP: begin
                rd_en   = 1'b1;
                state_d = DRIVE;
            end
            DRIVE: begin
                rom_data_d   = rd_data;
                fetch_addr_d = prev_addr_q;
                data_valid_d = 1'b1;
                state_d      = SEL_LO;
            end
            default: state_d = SEL_LO;
        endcase
    end

endmodule
